score_counter: RTL and testbench

- Holds the current game score and the session best score as three BCD digits each.
- Each output digit drives one seven-segment digit renderer instance in the pixel path, on its 4-bit number input.
- Point events arrive from the pipe/bird logic. Displayed digits change only on a frame boundary, so a digit never changes mid-frame.

---
 rtl/game_pkg.sv | 14 +
 rtl/bcd_digit.sv | 24 ++
 rtl/score_counter.sv | 112 +++++++++++
 tb/tb_score_counter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the score/best-score BCD counter.
package game_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t        BCD_MAX      = 4'd9;
    localparam int unsigned SCORE_DIGITS = 3;

    // Packs a 0..999 value into three BCD digits {hundreds, tens, ones}.
    function automatic logic [11:0] to_bcd3(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of a BCD counter: wraps 9 -> 0 and ripples a carry to the next decade.
module bcd_digit
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       carry_in,
    output logic [3:0] digit,
    output logic       carry_out
);

    assign carry_out = (digit == BCD_MAX) & carry_in & en;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            digit <= '0;
        end else if (en && carry_in) begin
            digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/score_counter.sv
// Game score counter: BCD count of point events, frame-synchronous display latch,
// and a session best score committed on game_over.
module score_counter
    import game_pkg::*;
#(
    parameter int unsigned SAT_VALUE   = 999,
    parameter int unsigned EDGE_DETECT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       point,
    input  logic       frame_end,
    output logic [3:0] score_d0,
    output logic [3:0] score_d1,
    output logic [3:0] score_d2,
    output logic [3:0] best_d0,
    output logic [3:0] best_d1,
    output logic [3:0] best_d2,
    output logic       new_best,
    output logic       saturated
);

    localparam logic [11:0] SAT_BCD = to_bcd3(SAT_VALUE);

    logic        point_q;
    logic        inc;
    logic        at_sat;
    logic        count_en;
    logic [11:0] count;
    logic [11:0] score_q;
    logic [11:0] best_q;
    logic        carry0;
    logic        carry1;
    logic        carry2;
    logic        beats_best;

    assign inc        = (EDGE_DETECT != 0) ? (point & ~point_q) : point;
    assign at_sat     = (count == SAT_BCD);
    assign count_en   = inc & ~at_sat;
    // BCD digit ordering matches numeric ordering, so a plain compare suffices.
    assign beats_best = (count > best_q);

    bcd_digit u_d0 (
        .clk       (clk),
        .reset     (reset),
        .clear     (game_start),
        .en        (count_en),
        .carry_in  (1'b1),
        .digit     (count[3:0]),
        .carry_out (carry0)
    );

    bcd_digit u_d1 (
        .clk       (clk),
        .reset     (reset),
        .clear     (game_start),
        .en        (count_en),
        .carry_in  (carry0),
        .digit     (count[7:4]),
        .carry_out (carry1)
    );

    bcd_digit u_d2 (
        .clk       (clk),
        .reset     (reset),
        .clear     (game_start),
        .en        (count_en),
        .carry_in  (carry1),
        .digit     (count[11:8]),
        .carry_out (carry2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            point_q   <= 1'b0;
            score_q   <= '0;
            best_q    <= '0;
            new_best  <= 1'b0;
            saturated <= 1'b0;
        end else begin
            point_q <= point;
            // Top-digit carry only fires on a 999 wrap; folding it in keeps any wrap flagged.
            saturated <= game_start ? 1'b0 : (at_sat | carry2);

            if (game_start) begin
                score_q <= '0;
            end else if (frame_end) begin
                score_q <= count;
            end

            if (game_over && beats_best) begin
                best_q <= count;
            end

            if (game_start) begin
                new_best <= 1'b0;
            end else if (game_over && beats_best) begin
                new_best <= 1'b1;
            end
        end
    end

    assign score_d0 = score_q[3:0];
    assign score_d1 = score_q[7:4];
    assign score_d2 = score_q[11:8];
    assign best_d0  = best_q[3:0];
    assign best_d1  = best_q[7:4];
    assign best_d2  = best_q[11:8];

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: vector table, directed corner sequences
// and randomized traffic against an integer-arithmetic reference model.
module tb_score_counter;

    localparam int SAT = 999;

    logic       clk = 1'b0;
    logic       reset, game_start, game_over, point, frame_end;
    logic [3:0] score_d0, score_d1, score_d2;
    logic [3:0] best_d0, best_d1, best_d2;
    logic       new_best, saturated;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state, plain integers.
    int m_count, m_disp, m_best;
    bit m_nb, m_sat, m_prev;

    typedef struct {
        bit gs;
        bit go;
        bit pt;
        bit fe;
        int score;
        int best;
        bit nb;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    score_counter #(
        .SAT_VALUE   (SAT),
        .EDGE_DETECT (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .game_start (game_start),
        .game_over  (game_over),
        .point      (point),
        .frame_end  (frame_end),
        .score_d0   (score_d0),
        .score_d1   (score_d1),
        .score_d2   (score_d2),
        .best_d0    (best_d0),
        .best_d1    (best_d1),
        .best_d2    (best_d2),
        .new_best   (new_best),
        .saturated  (saturated)
    );

    function automatic int digits(input int v);
        return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int dut_score();
        return {20'd0, score_d2, score_d1, score_d0};
    endfunction

    function automatic int dut_best();
        return {20'd0, best_d2, best_d1, best_d0};
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check_val("score", dut_score(), digits(m_disp));
        check_val("best", dut_best(), digits(m_best));
        check_val("new_best", int'(new_best), int'(m_nb));
        check_val("saturated", int'(saturated), int'(m_sat));
    endtask

    task automatic model_step(input bit rst, input bit gs, input bit go,
                              input bit pt, input bit fe);
        bit inc;
        if (rst) begin
            m_count = 0; m_disp = 0; m_best = 0;
            m_nb = 0; m_sat = 0; m_prev = 0;
        end else begin
            inc = pt && !m_prev;
            if (go && m_count > m_best) begin
                m_best = m_count;
                m_nb   = 1;
            end
            if (gs) m_nb = 0;
            m_sat = !gs && (m_count == SAT);
            if (gs) m_disp = 0;
            else if (fe) m_disp = m_count;
            if (gs) m_count = 0;
            else if (inc && m_count < SAT) m_count++;
            m_prev = pt;
        end
    endtask

    task automatic tick(input bit rst, input bit gs, input bit go,
                        input bit pt, input bit fe);
        reset = rst; game_start = gs; game_over = go; point = pt; frame_end = fe;
        @(posedge clk);
        model_step(rst, gs, go, pt, fe);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 0, 0, 1, 0);
            tick(0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; game_start = 0; game_over = 0; point = 0; frame_end = 0;
        m_count = 0; m_disp = 0; m_best = 0; m_nb = 0; m_sat = 0; m_prev = 0;

        // {gs, go, pt, fe, score, best, new_best} from reset
        tbl[0]  = '{0, 0, 1, 0, 'h000, 'h000, 0};
        tbl[1]  = '{0, 0, 0, 1, 'h001, 'h000, 0};
        tbl[2]  = '{0, 0, 1, 1, 'h001, 'h000, 0};
        tbl[3]  = '{0, 0, 0, 1, 'h002, 'h000, 0};
        tbl[4]  = '{0, 1, 0, 0, 'h002, 'h002, 1};
        tbl[5]  = '{1, 0, 0, 0, 'h000, 'h002, 0};
        tbl[6]  = '{1, 0, 1, 0, 'h000, 'h002, 0};
        tbl[7]  = '{0, 0, 0, 1, 'h000, 'h002, 0};
        tbl[8]  = '{0, 0, 1, 0, 'h000, 'h002, 0};
        tbl[9]  = '{0, 1, 1, 0, 'h000, 'h002, 0};
        tbl[10] = '{0, 0, 0, 1, 'h001, 'h002, 0};
        tbl[11] = '{1, 1, 0, 0, 'h000, 'h002, 0};

        do_reset();
        check_val("reset_score", dut_score(), 0);
        check_val("reset_best", dut_best(), 0);
        check_val("reset_new_best", int'(new_best), 0);
        check_val("reset_saturated", int'(saturated), 0);

        for (int i = 0; i < 12; i++) begin
            tick(0, tbl[i].gs, tbl[i].go, tbl[i].pt, tbl[i].fe);
            check_val($sformatf("tbl%0d_score", i), dut_score(), tbl[i].score);
            check_val($sformatf("tbl%0d_best", i), dut_best(), tbl[i].best);
            check_val($sformatf("tbl%0d_nb", i), int'(new_best), int'(tbl[i].nb));
        end

        // 12 edges, point held 3 cycles each; display waits for frame_end.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            repeat (3) tick(0, 0, 0, 1, 0);
            idle();
        end
        check_val("twelve_before_fe", dut_score(), 'h000);
        tick(0, 0, 0, 0, 1);
        check_val("twelve_after_fe", dut_score(), 'h012);

        // Two-digit carry 099 -> 100.
        edges(87);
        tick(0, 0, 0, 0, 1);
        check_val("score_099", dut_score(), 'h099);
        edges(1);
        tick(0, 0, 0, 0, 1);
        check_val("score_100", dut_score(), 'h100);

        // Saturation at 999.
        tick(0, 1, 0, 0, 0);
        edges(998);
        edges(3);
        idle();
        idle();
        check_val("sat_flag", int'(saturated), 1);
        tick(0, 0, 0, 0, 1);
        check_val("sat_display", dut_score(), 'h999);

        // Best score commit and retention.
        tick(0, 1, 0, 0, 0);
        edges(45);
        tick(0, 0, 1, 0, 0);
        check_val("best_045", dut_best(), 'h045);
        check_val("nb_after_045", int'(new_best), 1);
        tick(0, 1, 0, 0, 0);
        check_val("nb_cleared", int'(new_best), 0);
        edges(30);
        tick(0, 0, 1, 0, 0);
        check_val("best_kept_045", dut_best(), 'h045);
        check_val("nb_after_030", int'(new_best), 0);

        // game_over with game_start: compare pre-clear, new_best cleared.
        tick(0, 1, 0, 0, 0);
        edges(60);
        tick(0, 1, 1, 0, 0);
        check_val("go_gs_best", dut_best(), 'h060);
        check_val("go_gs_nb", int'(new_best), 0);

        // game_start with a point edge at 007.
        tick(0, 1, 0, 0, 0);
        edges(7);
        tick(0, 1, 0, 1, 1);
        check_val("gs_pt_score", dut_score(), 'h000);
        check_val("gs_pt_nb", int'(new_best), 0);
        tick(0, 0, 0, 0, 1);
        check_val("gs_pt_count", dut_score(), 'h000);

        // Reset mid-game with best 120 and score 050.
        tick(0, 1, 0, 0, 0);
        edges(120);
        tick(0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0);
        edges(50);
        tick(0, 0, 0, 0, 1);
        check_val("pre_reset_best", dut_best(), 'h120);
        check_val("pre_reset_score", dut_score(), 'h050);
        tick(1, 0, 0, 1, 0);
        check_val("rst_score", dut_score(), 0);
        check_val("rst_best", dut_best(), 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        check_val("rst_no_count", dut_score(), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(999) == 0),
                 ($urandom_range(199) == 0),
                 ($urandom_range(49) == 0),
                 ($urandom_range(1) == 1),
                 ($urandom_range(19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
